// File: rtl/wb_mean_sched.sv
// rtl/wb_mean_sched.sv - frame sequencer feeding the white-balance per-channel mean accumulator
module wb_mean_sched #(
    parameter int TIMEOUT  = 64,
    parameter int MAX_LOG2 = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [3:0] log2_w_i,
    input  logic [3:0] log2_h_i,
    input  logic       pix_valid_i,
    input  logic [7:0] pix_value_i,
    output logic       pix_ready_o,
    output logic       acc_clr_o,
    output logic       acc_valid_o,
    output logic [1:0] acc_color_o,
    output logic [7:0] acc_value_o,
    output logic       acc_last_o,
    output logic [4:0] acc_size_o,
    input  logic       acc_finish_i,
    input  logic [7:0] r_mean_i,
    input  logic [7:0] g_mean_i,
    input  logic [7:0] b_mean_i,
    output logic [7:0] r_mean_o,
    output logic [7:0] g_mean_o,
    output logic [7:0] b_mean_o,
    output logic       done_o,
    output logic       busy_o,
    output logic       err_o
);
    localparam int CNT_W = MAX_LOG2;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_RUN, S_WAIT, S_CAP} state_t;

    state_t             state_q, state_d;
    logic [4:0]         size_q, size_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         plane_q, plane_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               av_q, av_d;
    logic [1:0]         col_q, col_d;
    logic [7:0]         val_q, val_d;
    logic               last_q, last_d;
    logic [7:0]         r_q, r_d, g_q, g_d, b_q, b_d;

    logic [4:0]         cfg_sum;
    logic               cfg_ok;
    logic               fire;
    logic [CNT_W:0]     plane_len;
    logic               plane_last;

    always_comb begin
        cfg_sum    = {1'b0, log2_w_i} + {1'b0, log2_h_i};
        cfg_ok     = (cfg_sum != 5'd0) && (cfg_sum <= 5'(MAX_LOG2));
        fire       = (state_q == S_RUN) && pix_valid_i;
        plane_len  = (CNT_W + 1)'(1) << size_q;
        plane_last = ({1'b0, cnt_q} == (plane_len - (CNT_W + 1)'(1)));
    end

    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        plane_d = plane_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        av_d    = fire;
        col_d   = col_q;
        val_d   = val_q;
        last_d  = fire && plane_last;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cfg_ok) begin
                        state_d = S_CLR;
                        size_d  = cfg_sum;
                        err_d   = 1'b0;
                    end else begin
                        err_d   = 1'b1;
                    end
                end
            end
            S_CLR: begin
                cnt_d   = '0;
                plane_d = 2'd0;
                tmo_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (fire) begin
                    col_d = plane_q;
                    val_d = pix_value_i;
                    if (plane_last) begin
                        cnt_d   = '0;
                        plane_d = plane_q + 2'd1;
                        if (plane_q == 2'd2) begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_WAIT: begin
                // Finish wins over a timeout landing on the same cycle.
                if (acc_finish_i) begin
                    state_d = S_CAP;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_CAP: begin
                r_d     = r_mean_i;
                g_d     = g_mean_i;
                b_d     = b_mean_i;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            size_q  <= '0;
            cnt_q   <= '0;
            plane_q <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            av_q    <= 1'b0;
            col_q   <= '0;
            val_q   <= '0;
            last_q  <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            plane_q <= plane_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            av_q    <= av_d;
            col_q   <= col_d;
            val_q   <= val_d;
            last_q  <= last_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
        end
    end

    assign pix_ready_o = (state_q == S_RUN);
    assign acc_clr_o   = (state_q == S_CLR);
    assign done_o      = (state_q == S_CAP);
    assign busy_o      = (state_q != S_IDLE);
    assign err_o       = err_q;
    assign acc_valid_o = av_q;
    assign acc_color_o = col_q;
    assign acc_value_o = val_q;
    assign acc_last_o  = last_q;
    assign acc_size_o  = size_q;
    assign r_mean_o    = r_q;
    assign g_mean_o    = g_q;
    assign b_mean_o    = b_q;
endmodule

// File: tb/tb_wb_mean_sched.sv
// tb/tb_wb_mean_sched.sv - directed self-checking bench for wb_mean_sched
module tb_wb_mean_sched;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic [3:0] log2_w_i = '0, log2_h_i = '0;
    logic       pix_valid_i = 1'b0;
    logic [7:0] pix_value_i = '0;
    logic       pix_ready_o, acc_clr_o, acc_valid_o, acc_last_o;
    logic [1:0] acc_color_o;
    logic [7:0] acc_value_o;
    logic [4:0] acc_size_o;
    logic       acc_finish_i = 1'b0;
    logic [7:0] r_mean_i = '0, g_mean_i = '0, b_mean_i = '0;
    logic [7:0] r_mean_o, g_mean_o, b_mean_o;
    logic       done_o, busy_o, err_o;

    int n_cmp = 0;
    int n_err = 0;
    int clr_cnt = 0;
    int done_cnt = 0;
    logic [1:0] q_col[$];
    logic [7:0] q_val[$];
    logic       q_last[$];

    wb_mean_sched #(.TIMEOUT(64), .MAX_LOG2(20)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i),
        .log2_w_i(log2_w_i), .log2_h_i(log2_h_i),
        .pix_valid_i(pix_valid_i), .pix_value_i(pix_value_i), .pix_ready_o(pix_ready_o),
        .acc_clr_o(acc_clr_o), .acc_valid_o(acc_valid_o), .acc_color_o(acc_color_o),
        .acc_value_o(acc_value_o), .acc_last_o(acc_last_o), .acc_size_o(acc_size_o),
        .acc_finish_i(acc_finish_i),
        .r_mean_i(r_mean_i), .g_mean_i(g_mean_i), .b_mean_i(b_mean_i),
        .r_mean_o(r_mean_o), .g_mean_o(g_mean_o), .b_mean_o(b_mean_o),
        .done_o(done_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Capture accumulator-side traffic on the falling edge, away from state updates.
    always @(negedge clk) begin
        if (acc_valid_o) begin
            q_col.push_back(acc_color_o);
            q_val.push_back(acc_value_o);
            q_last.push_back(acc_last_o);
        end
        if (acc_clr_o) clr_cnt++;
        if (done_o) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix_val(input int idx, input int base);
        return 8'(base + 10 * (idx / 4 + 1));
    endfunction

    task automatic clear_mon();
        q_col.delete();
        q_val.delete();
        q_last.delete();
        clr_cnt = 0;
        done_cnt = 0;
    endtask

    task automatic start_frame(input logic [3:0] w, input logic [3:0] h);
        start_i = 1'b1;
        log2_w_i = w;
        log2_h_i = h;
        tick();
        start_i = 1'b0;
    endtask

    // Streams 12 pixels of a size-2 frame; optional valid toggling, mid-RUN start, early stop.
    task automatic stream(input bit toggle, input int inject_at, input int stop_after, input int base);
        int idx = 0;
        int cyc = 0;
        bit acc;
        while (idx < 12 && idx != stop_after && cyc < 100) begin
            pix_valid_i = toggle ? cyc[0] : 1'b1;
            pix_value_i = pix_val(idx, base);
            start_i = (idx == inject_at);
            acc = pix_valid_i && pix_ready_o;
            tick();
            if (acc) idx++;
            cyc++;
        end
        pix_valid_i = 1'b0;
        start_i = 1'b0;
        chk("stream_accepted", idx, (stop_after >= 0) ? stop_after : 12);
    endtask

    task automatic check_stream(input int base);
        chk("out_count", q_col.size(), 12);
        for (int i = 0; i < 12 && i < q_col.size(); i++) begin
            chk($sformatf("color[%0d]", i), q_col[i], i / 4);
            chk($sformatf("value[%0d]", i), q_val[i], pix_val(i, base));
            chk($sformatf("last[%0d]", i), q_last[i], (i % 4) == 3);
        end
    endtask

    task automatic finish_frame(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        tick();
        acc_finish_i = 1'b1;
        r_mean_i = r;
        g_mean_i = g;
        b_mean_i = b;
        tick();
        acc_finish_i = 1'b0;
        chk("cap_done", done_o, 1);
        chk("cap_busy", busy_o, 1);
        chk("cap_size", acc_size_o, 2);
        tick();
        chk("idle_busy", busy_o, 0);
        chk("idle_done", done_o, 0);
        chk("r_mean", r_mean_o, r);
        chk("g_mean", g_mean_o, g);
        chk("b_mean", b_mean_o, b);
        chk("done_pulses", done_cnt, 1);
    endtask

    initial begin
        int n;
        // Reset state
        tick();
        tick();
        chk("rst_busy", busy_o, 0);
        chk("rst_ready", pix_ready_o, 0);
        chk("rst_valid", acc_valid_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_size", acc_size_o, 0);
        chk("rst_rmean", r_mean_o, 0);
        rst_n = 1'b1;
        tick();

        // Frame 1: continuous stream
        clear_mon();
        start_frame(4'd1, 4'd1);
        chk("f1_clr", acc_clr_o, 1);
        chk("f1_size", acc_size_o, 2);
        chk("f1_ready_in_clr", pix_ready_o, 0);
        tick();
        chk("f1_ready_run", pix_ready_o, 1);
        stream(1'b0, -1, -1, 0);
        chk("f1_ready_wait", pix_ready_o, 0);
        finish_frame(8'd10, 8'd20, 8'd30);
        check_stream(0);
        chk("f1_clr_pulses", clr_cnt, 1);

        // Frame 2: valid toggling every other cycle
        clear_mon();
        start_frame(4'd1, 4'd1);
        tick();
        stream(1'b1, -1, -1, 5);
        finish_frame(8'd15, 8'd25, 8'd35);
        check_stream(5);

        // Illegal size 22 then a legal start that also exercises timeout
        clear_mon();
        start_frame(4'd12, 4'd10);
        chk("bad_err", err_o, 1);
        chk("bad_busy", busy_o, 0);
        chk("bad_clr", acc_clr_o, 0);
        tick();
        chk("bad_busy2", busy_o, 0);
        chk("bad_clr_pulses", clr_cnt, 0);
        start_frame(4'd1, 4'd1);
        chk("legal_err_clr", err_o, 0);
        chk("legal_clr", acc_clr_o, 1);
        tick();
        r_mean_i = 8'd99;
        g_mean_i = 8'd99;
        b_mean_i = 8'd99;
        stream(1'b0, -1, -1, 0);
        n = 0;
        while (busy_o && n < 200) begin
            n++;
            tick();
        end
        chk("tmo_wait_cycles", n, 64);
        chk("tmo_err", err_o, 1);
        chk("tmo_done", done_cnt, 0);
        chk("tmo_rmean", r_mean_o, 15);
        chk("tmo_gmean", g_mean_o, 25);
        chk("tmo_bmean", b_mean_o, 35);

        // Start pulsed mid-RUN is ignored
        clear_mon();
        start_frame(4'd1, 4'd0);
        start_frame(4'd1, 4'd1);
        chk("size1_clr", acc_clr_o, 0);
        chk("size1_busy", busy_o, 1);
        chk("size1_err", err_o, 0);
        n = 0;
        while (busy_o && n < 200) begin
            pix_valid_i = pix_ready_o;
            n++;
            tick();
        end
        pix_valid_i = 1'b0;
        tick();
        chk("size1_outputs", q_col.size(), 6);
        for (int i = 0; i < 6 && i < q_col.size(); i++) begin
            chk($sformatf("size1_last[%0d]", i), q_last[i], i[0]);
            chk($sformatf("size1_col[%0d]", i), q_col[i], i / 2);
        end
        clear_mon();
        start_frame(4'd1, 4'd1);
        chk("inj_err_clr", err_o, 0);
        tick();
        stream(1'b0, 5, -1, 1);
        finish_frame(8'd11, 8'd22, 8'd33);
        check_stream(1);
        chk("inj_clr_pulses", clr_cnt, 1);

        // Reset mid-frame, then a fresh frame
        clear_mon();
        start_frame(4'd1, 4'd1);
        tick();
        stream(1'b0, -1, 5, 2);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", busy_o, 0);
        chk("mrst_ready", pix_ready_o, 0);
        chk("mrst_valid", acc_valid_o, 0);
        chk("mrst_color", acc_color_o, 0);
        chk("mrst_size", acc_size_o, 0);
        chk("mrst_rmean", r_mean_o, 0);
        tick();
        rst_n = 1'b1;
        tick();
        clear_mon();
        start_frame(4'd1, 4'd1);
        chk("post_rst_clr", acc_clr_o, 1);
        tick();
        stream(1'b0, -1, -1, 3);
        finish_frame(8'd40, 8'd50, 8'd60);
        check_stream(3);
        chk("post_rst_clr_pulses", clr_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wb_mean_sched.md
Name: wb_mean_sched

Overview:
- Frame-level sequencer for the per-channel mean accumulator in the white-balance path.
- Accepts a planar frame (full R plane, then G, then B) over a valid/ready stream and tags each pixel with its colour.
- Marks the end of each plane, supplies the log2 frame size, waits for the accumulator's finish pulse, then latches the three means for the gain stage.
- Sits between the denoise output and the mean accumulator; one frame in flight at a time.

Parameters:
- TIMEOUT, 64, max cycles in WAIT before the finish pulse is declared missing
- MAX_LOG2, 20, max allowed log2_w_i+log2_h_i (accumulator is 28 bits = 8+20)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  pulse: begin a frame; config sampled this cycle
- log2_w_i  in  4  log2 of plane width
- log2_h_i  in  4  log2 of plane height
- pix_valid_i  in  1  input pixel valid
- pix_value_i  in  8  input pixel
- pix_ready_o  out  1  input accept; transfer when valid&ready
- acc_clr_o  out  1  one-cycle accumulator clear pulse
- acc_valid_o  out  1  pixel valid to accumulator
- acc_color_o  out  2  0=R, 1=G, 2=B
- acc_value_o  out  8  pixel to accumulator
- acc_last_o  out  1  last pixel of the current plane
- acc_size_o  out  5  log2_w+log2_h of the active frame
- acc_finish_i  in  1  accumulator finish pulse
- r_mean_i, g_mean_i, b_mean_i  in  8 each  accumulator means
- r_mean_o, g_mean_o, b_mean_o  out  8 each  latched means of the last completed frame
- done_o  out  1  one-cycle pulse: means updated
- busy_o  out  1  high in every state except IDLE
- err_o  out  1  sticky: bad config or finish timeout; cleared by next accepted start_i

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, means_o 0.
- States:
  - IDLE: start_i moves to CLR if 1 <= log2_w_i+log2_h_i <= MAX_LOG2. Otherwise err_o=1 and the FSM stays in IDLE.
  - CLR: one cycle. acc_clr_o=1. Latch size. pix_cnt=0, plane=0. Then RUN.
  - RUN: pix_ready_o=1. Each accepted pixel is registered to the acc_* outputs one cycle later.
    - acc_color_o = plane.
    - acc_last_o=1 when pix_cnt == 2^size-1; on that pixel pix_cnt wraps to 0 and plane increments.
    - Accepting the last B pixel moves the FSM to WAIT, and pix_ready_o drops the following cycle.
  - WAIT: pix_ready_o=0. Timeout counter increments.
    - acc_finish_i moves the FSM to CAP.
    - Counter reaching TIMEOUT sets err_o=1 and moves the FSM to IDLE; means are not updated.
  - CAP: latch r/g/b_mean_i into *_mean_o. done_o=1 for this single cycle. Then IDLE.
- acc_valid_o is 0 in any cycle with no transfer the previous cycle. acc_value_o and acc_color_o hold their last value when invalid.
- acc_size_o holds the latched size outside RUN and is stable from CLR through CAP.
- Throughput: 1 pixel/cycle. Total pixels = 3·2^size. Start-to-first-ready latency = 2 cycles (IDLE→CLR→RUN).
- start_i while busy_o=1 is ignored; no err, no restart.
- acc_finish_i outside WAIT is ignored.
- pix_valid_i when pix_ready_o=0 is not consumed; the source must hold it.
- Reset mid-frame returns everything to reset values immediately. The next frame's CLR pulse re-initialises the accumulator.
- size=1 (2-pixel planes) is legal: acc_last_o on every second pixel.

Test Plan:
- Reset, then start with w=1,h=1 (size 2), stream R=4×10, G=4×20, B=4×30, finish 2 cycles after the last B pixel with means 10/20/30 -> acc_last_o on pixels 4, 8, 12; colours 0,0,0,0,1,…,2; done_o pulse; r/g/b_mean_o = 10/20/30; busy_o low after CAP.
- Same frame with pix_valid_i toggling every other cycle -> no pixel lost or duplicated; acc_valid_o count = 12; acc_last_o on the 4th, 8th and 12th valid output only.
- start with log2_w=12, log2_h=10 (size 22) -> err_o=1, busy_o stays 0, no acc_clr_o; a following legal start clears err_o.
- Legal frame with finish never asserted, TIMEOUT=64 -> WAIT lasts exactly 64 cycles, err_o=1, done_o never pulses, means_o keep their previous values.
- start_i pulsed mid-RUN -> ignored; plane and pixel counts continue; acc_clr_o does not pulse.
- rst_n dropped after 5 of 12 pixels, then a fresh start -> all outputs 0 during reset; new frame gets an acc_clr_o pulse and completes normally with correct plane tagging.
